// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (req0: EX stage,
// req1: multicycle helper unit). The winning request is registered into an
// issue stage that drives the ALU. The ALU result is then captured into a
// response register, which supports backpressure. Operation codes pass
// through unmodified, and the block does no arithmetic of its own.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin arbitration with a one-bit pointer
//                  undefined -> fixed priority, req0 always wins
//
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   req0_valid/ready/op/a/b         requester 0 (EX stage) handshake + payload
//   req1_valid/ready/op/a/b         requester 1 (helper unit) handshake + payload
//   alu_op, alu_a, alu_b            issue register, drives the external ALU
//   alu_result                      combinational result from the ALU
//   rsp_valid/ready/id/result       registered response to the consumer
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result
);

    logic              issue_valid;
    logic              issue_id;
    logic              resp_free;
    logic              issue_adv;
    logic              can_accept;
    logic              grant_id;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Handshake chain: the response register frees first. The issue stage
    // can then move forward, and only after that can a new request be taken.
    assign resp_free  = !rsp_valid || rsp_ready;
    assign issue_adv  = issue_valid && resp_free;
    assign can_accept = !issue_valid || issue_adv;

`ifdef ALU_ARB_RR_EN
    logic rr_ptr;

    // The pointer only settles contention. A lone valid requester always
    // wins. With no valid requester, the preferred one is shown ready.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_id = rr_ptr;
        if (req0_valid && !req1_valid) begin
            grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end
`else
    // Fixed priority: req1 is granted only when req0 is idle.
    always_comb begin
        grant_id = !req0_valid && req1_valid;
    end
`endif

    // Exactly one ready can be high, and only when the issue stage can load.
    // The granted ready may be high while its valid is low.
    assign req0_ready = can_accept && !grant_id;
    assign req1_ready = can_accept &&  grant_id;
    assign accept     = can_accept && (grant_id ? req1_valid : req0_valid);

    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant_id) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // Issue stage. On advance with no new accept, only the valid bit drops.
    // The operand registers keep their last value.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the two stages shift as one pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_valid <= 1'b0;
            issue_id    <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else if (accept) begin
            issue_valid <= 1'b1;
            issue_id    <= grant_id;
            alu_op      <= sel_op;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
        end else if (issue_adv) begin
            issue_valid <= 1'b0;
        end
    end

    // Response stage. A new result overwrites a response that is being
    // consumed on the same edge, so the stream has no bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else if (issue_adv) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= issue_id;
            rsp_result <= alu_result;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. The ALU is a stand-in function that responds to the
// DUT's issue register. A transaction-level model tracks every accepted
// operation from accept to consumption. From its age and position it derives
// rsp_valid, the response payload, the issue-register contents, how many
// readys may be high, and which requester must win.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct {
        logic          id;
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        int            cyc;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OW-1:0] req0_op, req1_op, alu_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_result;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    ncons   = 0;
    bit    rand_mode = 1'b0;
    bit    fire0 = 1'b0, fire1 = 1'b0;
    bit    ptr = 1'b0;
    op_t   q0[$], q1[$];
    item_t sb[$];
    bit    glog[$];

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a + b;
            4'b0100: return a - b;
            4'b1001: return (a == b) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic [OW-1:0] ops [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b1001, 4'b0010};
        o.op = ops[$urandom_range(0, 5)];
        o.a  = $urandom;
        o.b  = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
        return o;
    endfunction

    // Compare process: checks the DUT against the transaction model, then
    // applies this cycle's handshakes to the model.
    always @(negedge clk) begin
        bit exp_rv, exp_any, w;
        item_t it;
        cyc++;
        if (!reset) begin
            sb.delete();
            glog.delete();
            ptr   = 1'b0;
            fire0 = 1'b0;
            fire1 = 1'b0;
        end else begin
            // The oldest item has reached the response register once it has
            // been in flight for two cycles.
            exp_rv = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
            check("rsp_valid", rsp_valid, exp_rv);
            if (rsp_valid && exp_rv) begin
                check("rsp_id", rsp_id, sb[0].id);
                check("rsp_result", rsp_result, sb[0].res);
            end
            // The newest item sits in the issue register unless it has
            // already moved on.
            if (sb.size() == 2 || (sb.size() == 1 && sb[0].cyc == cyc - 1)) begin
                it = sb[sb.size()-1];
                check("alu_op", alu_op, it.op);
                check("alu_a", alu_a, it.a);
                check("alu_b", alu_b, it.b);
            end
            // Two slots are in flight. A new accept fits only if the
            // consumer frees one this cycle.
            exp_any = (sb.size() < 2) || rsp_ready;
            check("ready_excl", req0_ready & req1_ready, 1'b0);
            check("ready_any", req0_ready | req1_ready, exp_any);
            if (req0_valid && req1_valid && exp_any) begin
                w = RR ? ptr : 1'b0;
                check("winner", req1_ready, w);
            end else if (req0_valid && !req1_valid) begin
                check("req0_ready", req0_ready, exp_any);
            end else if (req1_valid && !req0_valid) begin
                check("req1_ready", req1_ready, exp_any);
            end

            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                ncons++;
            end
            fire0 = req0_valid && req0_ready;
            fire1 = req1_valid && req1_ready;
            if (fire0 || fire1) begin
                it.id  = fire1;
                it.op  = fire1 ? req1_op : req0_op;
                it.a   = fire1 ? req1_a  : req0_a;
                it.b   = fire1 ? req1_b  : req0_b;
                it.res = alu_f(it.op, it.a, it.b);
                it.cyc = cyc;
                sb.push_back(it);
                glog.push_back(fire1);
                ptr = ~fire1;
            end
        end
    end

    // Requester driver: each requester holds its offer until it is accepted,
    // then takes the next one from its queue in the same cycle.
    always @(posedge clk) begin
        op_t o;
        #1;
        if (!reset) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end else begin
            if (fire0) req0_valid = 1'b0;
            if (fire1) req1_valid = 1'b0;
            if (rand_mode) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rand_op());
                if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rand_op());
            end
            if (!req0_valid && q0.size() > 0) begin
                o = q0.pop_front();
                req0_valid = 1'b1; req0_op = o.op; req0_a = o.a; req0_b = o.b;
            end
            if (!req1_valid && q1.size() > 0) begin
                o = q1.pop_front();
                req1_valid = 1'b1; req1_op = o.op; req1_a = o.a; req1_b = o.b;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            idle = (q0.size() == 0) && (q1.size() == 0) && !req0_valid &&
                   !req1_valid && (sb.size() == 0) && !rsp_valid;
            if (idle) break;
        end
        check(name, idle, 1'b1);
    endtask

    // One op on req0 with an idle pipeline: fixed cycle-by-cycle expectations.
    task automatic single_op(input string tag, input logic [OW-1:0] op,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] exp_res);
        op_t o;
        o.op = op; o.a = a; o.b = b;
        step();
        q0.push_back(o);
        @(posedge clk);                  // cycle N: driver offers the op
        @(negedge clk);
        check({tag, "_ready_N"}, req0_ready, 1'b1);
        @(negedge clk);                  // N+1
        check({tag, "_alu_op_N1"}, alu_op, op);
        check({tag, "_alu_a_N1"}, alu_a, a);
        check({tag, "_alu_b_N1"}, alu_b, b);
        @(negedge clk);                  // N+2
        check({tag, "_rsp_valid_N2"}, rsp_valid, 1'b1);
        check({tag, "_rsp_id_N2"}, rsp_id, 1'b0);
        check({tag, "_rsp_result_N2"}, rsp_result, exp_res);
    endtask

    initial begin
        op_t o;
        int  n0, run;
        bit  seen;
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_alu_op", alu_op, '0);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_b", alu_b, '0);
        step();
        reset = 1'b1;

        // Single add: 5 + 7 = 12.
        single_op("add", 4'b0011, 32'd5, 32'd7, 32'd12);
        wait_drain("drain_single");

        // Back-to-back stream from req1.
        step();
        for (int i = 0; i < 4; i++) begin
            o.op = 4'b0011; o.a = 32'(i * 10); o.b = 32'd1;
            q1.push_back(o);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        run = 0;
        while (rsp_valid && run < 10) begin
            check("b2b_id", rsp_id, 1'b1);
            check("b2b_result", rsp_result, 32'(run * 10 + 1));
            run++;
            @(negedge clk);
        end
        check("b2b_run_length", run, 4);
        wait_drain("drain_b2b");

        // Backpressure: three ops against a stalled consumer.
        step();
        rsp_ready = 1'b0;
        n0 = ncons;
        for (int i = 1; i <= 3; i++) begin
            o.op = 4'b0011; o.a = 32'(i); o.b = 32'(i);
            q0.push_back(o);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        check("bp_rsp_result", rsp_result, 32'd2);
        check("bp_issue_a", alu_a, 32'd2);
        check("bp_req0_ready", req0_ready, 1'b0);
        check("bp_req1_ready", req1_ready, 1'b0);
        step();
        rsp_ready = 1'b1;
        wait_drain("drain_bp");
        check("bp_consumed", ncons - n0, 3);

        // Contention on both requesters from a fresh pointer.
        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin
            o.op = 4'b0100; o.a = 32'(100 + i); o.b = 32'(i);
            q0.push_back(o);
            o.op = 4'b0001; o.a = 32'(i << 4); o.b = 32'(i);
            q1.push_back(o);
        end
        for (int i = 0; i < 40 && glog.size() < 6; i++) @(negedge clk);
        check("contention_grants", glog.size() >= 6, 1'b1);
        if (glog.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("grant%0d", i), glog[i], RR ? 1'(i % 2) : 1'b0);
            end
        end
        wait_drain("drain_contention");

        // Reset while an op is in the issue stage.
        step();
        o.op = 4'b0011; o.a = 32'd40; o.b = 32'd2;
        q0.push_back(o);
        @(posedge clk);                  // N: accept
        @(posedge clk);                  // N+1: op in issue
        #2;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);                  // N+2
        check("midrst_rsp_valid_N2", rsp_valid, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_rsp_valid_after", rsp_valid, 1'b0);
        end
        single_op("postrst", 4'b0100, 32'd9, 32'd4, 32'd5);
        wait_drain("drain_postrst");

        // Branch compare op.
        single_op("beq", 4'b1001, 32'd3, 32'd3, 32'd1);
        wait_drain("drain_beq");

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        repeat (3000) @(posedge clk);
        #2;
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
